// File: rtl/remap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : remap_pkg
//  Description : Shared types and default constants for the remap controller.
//  Revision    : 1.0
// ============================================================================
package remap_pkg;

    localparam int c_n_init_port     = 8;
    localparam int c_log_n_init      = 3;
    localparam int c_max_outstanding = 16;
    localparam int c_timeout_cycles  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RESP_OK       = 2'b00,
        RESP_BAD_PORT = 2'b01,
        RESP_TIMEOUT  = 2'b10
    } resp_code_e;

endpackage
`default_nettype wire

// File: rtl/remap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : remap_ctrl_if
//  Description : Request, traffic-monitor, commit and response signals of the
//                remap controller; slave = controller, master = requester.
//  Revision    : 1.0
// ============================================================================
interface remap_ctrl_if #(
    parameter int LOG_N_INIT = 3,
    parameter int CNT_W      = 5
);
    import remap_pkg::*;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [LOG_N_INIT-1:0] req_source_i;
    logic [LOG_N_INIT-1:0] req_target_i;
    logic                  aw_issue_i;
    logic                  b_done_i;
    logic                  block_aw_o;
    logic                  select_o;
    logic [LOG_N_INIT-1:0] source_o;
    logic [LOG_N_INIT-1:0] target_o;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    resp_code_e            resp_code_o;
    logic [CNT_W-1:0]      outstanding_o;

    modport slave (
        input  req_valid_i, req_source_i, req_target_i, aw_issue_i, b_done_i, resp_ready_i,
        output req_ready_o, block_aw_o, select_o, source_o, target_o,
               resp_valid_o, resp_code_o, outstanding_o
    );

    modport master (
        output req_valid_i, req_source_i, req_target_i, aw_issue_i, b_done_i, resp_ready_i,
        input  req_ready_o, block_aw_o, select_o, source_o, target_o,
               resp_valid_o, resp_code_o, outstanding_o
    );

endinterface
`default_nettype wire

// File: rtl/remap_outst_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : remap_outst_cnt
//  Description : Saturating count of write transactions in flight.
//  Revision    : 1.0
// ============================================================================
module remap_outst_cnt
    import remap_pkg::*;
#(
    parameter int MAX_OUTSTANDING = c_max_outstanding
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst_n,
    input  wire logic                                 inc_i,
    input  wire logic                                 dec_i,
    input  wire logic                                 clear_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      count_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Simultaneous inc/dec cancel; a spurious decrement at zero is dropped.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i && (count_q != CNT_W'(MAX_OUTSTANDING))) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/remap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : remap_ctrl
//  Description : Drains in-flight writes, then commits a port remap with a
//                single-cycle select strobe and reports the outcome.
//  Revision    : 1.0
// ============================================================================
module remap_ctrl
    import remap_pkg::*;
#(
    parameter int N_INIT_PORT     = c_n_init_port,
    parameter int LOG_N_INIT      = c_log_n_init,
    parameter int MAX_OUTSTANDING = c_max_outstanding,
    parameter int TIMEOUT_CYCLES  = c_timeout_cycles
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    remap_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                state_q, state_d;
    resp_code_e            code_q, code_d;
    logic [LOG_N_INIT-1:0] src_q, src_d, tgt_q, tgt_d;
    logic [LOG_N_INIT-1:0] src_out_q, src_out_d, tgt_out_q, tgt_out_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      w_count;
    logic                  w_bad_port;
    logic                  w_drained;

    remap_outst_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outst_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (bus.aw_issue_i),
        .dec_i   (bus.b_done_i),
        .clear_i (1'b0),
        .count_o (w_count)
    );

    assign w_bad_port = (32'(bus.req_source_i) >= N_INIT_PORT)
                     || (32'(bus.req_target_i) >= N_INIT_PORT)
                     || (bus.req_source_i == bus.req_target_i);

    // An AW that slipped through in the same cycle is not yet in the count.
    assign w_drained = (w_count == '0) && !bus.aw_issue_i;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        src_d     = src_q;
        tgt_d     = tgt_q;
        src_out_d = src_out_q;
        tgt_out_d = tgt_out_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    src_d   = bus.req_source_i;
                    tgt_d   = bus.req_target_i;
                    timer_d = '0;
                    if (w_bad_port) begin
                        code_d  = RESP_BAD_PORT;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                timer_d = timer_q + TMR_W'(1);
                if (w_drained) begin
                    src_out_d = src_q;
                    tgt_out_d = tgt_q;
                    state_d   = ST_COMMIT;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    code_d  = RESP_TIMEOUT;
                    state_d = ST_RESP;
                end
            end
            ST_COMMIT: begin
                code_d  = RESP_OK;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= RESP_OK;
            src_q     <= '0;
            tgt_q     <= '0;
            src_out_q <= '0;
            tgt_out_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            src_q     <= src_d;
            tgt_q     <= tgt_d;
            src_out_q <= src_out_d;
            tgt_out_q <= tgt_out_d;
            timer_q   <= timer_d;
        end
    end

    // Blocking ends with COMMIT: the swap stage holds the new map by RESP.
    assign bus.block_aw_o    = (w_count == CNT_W'(MAX_OUTSTANDING))
                            || (state_q == ST_DRAIN) || (state_q == ST_COMMIT);
    assign bus.req_ready_o   = (state_q == ST_IDLE);
    assign bus.select_o      = (state_q == ST_COMMIT);
    assign bus.resp_valid_o  = (state_q == ST_RESP);
    assign bus.resp_code_o   = code_q;
    assign bus.source_o      = src_out_q;
    assign bus.target_o      = tgt_out_q;
    assign bus.outstanding_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_remap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_remap_ctrl
//  Description : Self-checking bench for remap_ctrl (6 ports, timeout 16).
//  Revision    : 1.0
// ============================================================================
module tb_remap_ctrl;
    import remap_pkg::*;

    localparam int N_PORT  = 6;
    localparam int LOG_N   = 3;
    localparam int MAX_OUT = 16;
    localparam int TMO     = 16;
    localparam int CNT_W   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    remap_ctrl_if #(.LOG_N_INIT(LOG_N), .CNT_W(CNT_W)) bus ();

    remap_ctrl #(
        .N_INIT_PORT     (N_PORT),
        .LOG_N_INIT      (LOG_N),
        .MAX_OUTSTANDING (MAX_OUT),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] src;
        logic [2:0] tgt;
        int         code;
        int         sel_cyc;
        int         resp_cyc;
    } vec_t;

    vec_t tv [6];
    int checks = 0;
    int errors = 0;
    int code, selc, seln, ss, st, rc, bl, br;
    int mcnt, last_src, last_tgt, exp_code;
    logic aw, b;
    logic [2:0] rs, rt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic d);
        bus.aw_issue_i = a;
        bus.b_done_i   = d;
        @(negedge clk);
        bus.aw_issue_i = 1'b0;
        bus.b_done_i   = 1'b0;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_block"},  int'(bus.block_aw_o), 0);
        chk({tag, "_select"}, int'(bus.select_o), 0);
        chk({tag, "_rvalid"}, int'(bus.resp_valid_o), 0);
        chk({tag, "_code"},   int'(bus.resp_code_o), 0);
        chk({tag, "_source"}, int'(bus.source_o), 0);
        chk({tag, "_target"}, int'(bus.target_o), 0);
        chk({tag, "_outst"},  int'(bus.outstanding_o), 0);
    endtask

    // Called at a negedge in IDLE; cycle 0 is the acceptance cycle.
    task automatic run_req(input logic [2:0] s, input logic [2:0] t,
                           input logic [63:0] awm, input logic [63:0] bm, input bit ack,
                           output int o_code, output int o_selc, output int o_seln,
                           output int o_ss, output int o_st, output int o_rc,
                           output int o_bl, output int o_br);
        int c;
        o_code = -1; o_selc = 0; o_seln = 0; o_ss = -1; o_st = -1;
        o_rc = 0; o_bl = 0; o_br = -1;
        chk("req_ready_idle", int'(bus.req_ready_o), 1);
        bus.req_valid_i  = 1'b1;
        bus.req_source_i = s;
        bus.req_target_i = t;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        c = 1;
        while (c < 60) begin
            bus.aw_issue_i = awm[c];
            bus.b_done_i   = bm[c];
            if (bus.select_o) begin
                o_seln++;
                if (o_selc == 0) o_selc = c;
                o_ss = int'(bus.source_o);
                o_st = int'(bus.target_o);
            end
            if (bus.resp_valid_o) begin
                o_rc   = c;
                o_code = int'(bus.resp_code_o);
                o_br   = int'(bus.block_aw_o);
                break;
            end
            if (!bus.block_aw_o) o_bl++;
            @(negedge clk);
            c++;
        end
        bus.aw_issue_i = 1'b0;
        bus.b_done_i   = 1'b0;
        if (o_rc == 0) chk("resp_never_seen", 0, 1);
        if (ack && o_rc != 0) begin
            @(negedge clk);
            chk("resp_hold_valid", int'(bus.resp_valid_o), 1);
            chk("resp_hold_code", int'(bus.resp_code_o), o_code);
            bus.resp_ready_i = 1'b1;
            @(negedge clk);
            bus.resp_ready_i = 1'b0;
            chk("back_to_idle", int'(bus.req_ready_o), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i = 0; bus.req_source_i = 0; bus.req_target_i = 0;
        bus.aw_issue_i = 0; bus.b_done_i = 0; bus.resp_ready_i = 0;

        tv[0] = '{3'd1, 3'd4, 0, 2, 3};
        tv[1] = '{3'd7, 3'd2, 1, 0, 1};
        tv[2] = '{3'd2, 3'd6, 1, 0, 1};
        tv[3] = '{3'd3, 3'd3, 1, 0, 1};
        tv[4] = '{3'd0, 3'd5, 0, 2, 3};
        tv[5] = '{3'd5, 3'd0, 0, 2, 3};

        repeat (2) @(negedge clk);
        check_rst("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(bus.req_ready_o), 1);

        last_src = 0; last_tgt = 0;
        for (int i = 0; i < 6; i++) begin
            run_req(tv[i].src, tv[i].tgt, 64'd0, 64'd0, 1'b1, code, selc, seln, ss, st, rc, bl, br);
            chk($sformatf("vec%0d_code", i), code, tv[i].code);
            chk($sformatf("vec%0d_resp_cyc", i), rc, tv[i].resp_cyc);
            chk($sformatf("vec%0d_sel_n", i), seln, (tv[i].sel_cyc != 0) ? 1 : 0);
            if (tv[i].sel_cyc != 0) begin
                chk($sformatf("vec%0d_sel_cyc", i), selc, tv[i].sel_cyc);
                chk($sformatf("vec%0d_sel_src", i), ss, int'(tv[i].src));
                chk($sformatf("vec%0d_sel_tgt", i), st, int'(tv[i].tgt));
                last_src = int'(tv[i].src);
                last_tgt = int'(tv[i].tgt);
            end
            chk($sformatf("vec%0d_src_hold", i), int'(bus.source_o), last_src);
            chk($sformatf("vec%0d_tgt_hold", i), int'(bus.target_o), last_tgt);
        end

        // Three writes in flight, completions arrive mid-drain.
        repeat (3) cyc(1'b1, 1'b0);
        chk("drain3_outst", int'(bus.outstanding_o), 3);
        run_req(3'd2, 3'd5, 64'd0, (64'd1 << 4) | (64'd1 << 8) | (64'd1 << 12), 1'b1,
                code, selc, seln, ss, st, rc, bl, br);
        chk("drain3_code", code, 0);
        chk("drain3_sel_cyc", selc, 14);
        chk("drain3_sel_n", seln, 1);
        chk("drain3_sel_src", ss, 2);
        chk("drain3_sel_tgt", st, 5);
        chk("drain3_block_low", bl, 0);
        chk("drain3_block_resp", br, 0);
        last_src = 2; last_tgt = 5;

        // AW slips through in the first drain cycle.
        run_req(3'd0, 3'd1, 64'd1 << 1, 64'd1 << 5, 1'b1, code, selc, seln, ss, st, rc, bl, br);
        chk("lateaw_code", code, 0);
        chk("lateaw_sel_cyc", selc, 7);
        chk("lateaw_resp_cyc", rc, 8);
        last_src = 0; last_tgt = 1;

        // Timeout with one write that never completes.
        cyc(1'b1, 1'b0);
        run_req(3'd3, 3'd1, 64'd0, 64'd0, 1'b1, code, selc, seln, ss, st, rc, bl, br);
        chk("tmo_code", code, 2);
        chk("tmo_resp_cyc", rc, TMO + 1);
        chk("tmo_sel_n", seln, 0);
        chk("tmo_block_low", bl, 0);
        chk("tmo_block_resp", br, 0);
        chk("tmo_src_hold", int'(bus.source_o), last_src);
        cyc(1'b0, 1'b1);
        chk("tmo_outst_clear", int'(bus.outstanding_o), 0);

        // Counter corner cases.
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("cnt_both", int'(bus.outstanding_o), 2);
        repeat (2) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("cnt_dec_at_zero", int'(bus.outstanding_o), 0);
        repeat (15) cyc(1'b1, 1'b0);
        chk("cnt_15_block", int'(bus.block_aw_o), 0);
        cyc(1'b1, 1'b0);
        chk("cnt_16", int'(bus.outstanding_o), 16);
        chk("cnt_16_block", int'(bus.block_aw_o), 1);
        repeat (16) cyc(1'b0, 1'b1);

        // Random traffic against an integer occupancy model.
        mcnt = 0;
        for (int k = 0; k < 300; k++) begin
            aw = (mcnt < MAX_OUT) && ($urandom_range(0, 99) < ((k < 150) ? 70 : 30));
            b  = ($urandom_range(0, 99) < 40);
            cyc(aw, b);
            if (aw && !b) mcnt++;
            else if (b && !aw && mcnt > 0) mcnt--;
            chk("rnd_outst", int'(bus.outstanding_o), mcnt);
            chk("rnd_block", int'(bus.block_aw_o), (mcnt == MAX_OUT) ? 1 : 0);
        end
        while (mcnt > 0) begin
            cyc(1'b0, 1'b1);
            mcnt--;
        end
        chk("rnd_drained", int'(bus.outstanding_o), 0);

        // Random requests: outcome follows from the port-validity rule alone.
        for (int k = 0; k < 12; k++) begin
            rs = 3'($urandom_range(0, 7));
            rt = 3'($urandom_range(0, 7));
            exp_code = (int'(rs) >= N_PORT || int'(rt) >= N_PORT || rs == rt) ? 1 : 0;
            run_req(rs, rt, 64'd0, 64'd0, 1'b1, code, selc, seln, ss, st, rc, bl, br);
            chk("rreq_code", code, exp_code);
            chk("rreq_resp_cyc", rc, (exp_code == 0) ? 3 : 1);
            chk("rreq_sel_n", seln, (exp_code == 0) ? 1 : 0);
            if (exp_code == 0) begin
                chk("rreq_sel_src", ss, int'(rs));
                chk("rreq_sel_tgt", st, int'(rt));
                last_src = int'(rs);
                last_tgt = int'(rt);
            end
            chk("rreq_src_hold", int'(bus.source_o), last_src);
        end

        // Reset in the middle of DRAIN.
        if (last_src == 0 && last_tgt == 0) begin
            run_req(3'd4, 3'd2, 64'd0, 64'd0, 1'b1, code, selc, seln, ss, st, rc, bl, br);
        end
        cyc(1'b1, 1'b0);
        bus.req_valid_i  = 1'b1;
        bus.req_source_i = 3'd1;
        bus.req_target_i = 3'd2;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_drain_in_drain", int'(bus.block_aw_o), 1);
        #2 rst_n = 1'b0;
        #1 check_rst("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_drain_ready", int'(bus.req_ready_o), 1);
        chk("rst_drain_nosel", int'(bus.select_o), 0);

        // Reset while a response is waiting.
        run_req(3'd3, 3'd3, 64'd0, 64'd0, 1'b0, code, selc, seln, ss, st, rc, bl, br);
        @(negedge clk);
        chk("rst_resp_waiting", int'(bus.resp_valid_o), 1);
        chk("rst_resp_code", int'(bus.resp_code_o), 1);
        #2 rst_n = 1'b0;
        #1 check_rst("rst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(3'd1, 3'd4, 64'd0, 64'd0, 1'b1, code, selc, seln, ss, st, rc, bl, br);
        chk("post_rst_code", code, 0);
        chk("post_rst_sel_cyc", selc, 2);
        chk("post_rst_resp_cyc", rc, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
